lcd_hd44780_rx: RTL and testbench

//  Responder end of the HD44780 parallel bus driven by the lcd write controller.

---
 rtl/lcd_hd44780_rx.sv | 228 ++++++++++++++++++++++
 tb/tb_lcd_hd44780_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_rx.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_rx
// Responder end of an HD44780 8-bit parallel bus. Decodes EN/RS/RW/DATA
// strobes into instructions and character writes, keeps a 2x16 DDRAM shadow,
// emulates instruction busy time and answers busy-flag reads.
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready, accepting write commits
// CLEAR | clear in progress, blanking one shadow cell per cycle
// BUSY  | instruction executing, down-counting to terminal count 1
//
// Ports
//  CLK_I, RST_I          clock, async active-high reset
//  LCD_DATA_I/RS/RW/EN   bus from the write controller (EN falling = commit)
//  LCD_DATA_O, _OE_O     busy-flag read response {busy, AC}
//  BUSY_O, AC_O          executing flag, DDRAM address counter
//  DISP_ON_O, CUR_ON_O,
//  BLINK_O, ENTRY_INC_O,
//  FUNC_O                display control / entry mode / function set state
//  CMD_ERR_O             1-cycle pulse when a write arrives while busy
//  RD_ADDR_I, RD_CHAR_O  shadow read port, 1-cycle latency
// ---------------------------------------------------------------------------
module lcd_hd44780_rx #(
    parameter int PAYLOAD_BITS = 8,
    parameter int CMD_CYCLES   = 2000,
    parameter int CLR_CYCLES   = 82000
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic [PAYLOAD_BITS-1:0] LCD_DATA_I,
    input  logic                    LCD_RS_I,
    input  logic                    LCD_RW_I,
    input  logic                    LCD_EN_I,
    output logic [PAYLOAD_BITS-1:0] LCD_DATA_O,
    output logic                    LCD_DATA_OE_O,
    output logic                    BUSY_O,
    output logic [6:0]              AC_O,
    output logic                    DISP_ON_O,
    output logic                    CUR_ON_O,
    output logic                    BLINK_O,
    output logic                    ENTRY_INC_O,
    output logic [2:0]              FUNC_O,
    output logic                    CMD_ERR_O,
    input  logic [4:0]              RD_ADDR_I,
    output logic [7:0]              RD_CHAR_O
);

    localparam int CNT_MAX = (CLR_CYCLES > CMD_CYCLES) ? CLR_CYCLES : CMD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BUS_W   = PAYLOAD_BITS + 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // {EN, RS, RW, DATA} through two sync stages plus one delay stage
    logic [BUS_W-1:0] sync1_q, sync2_q, sync3_q;

    logic                    en_s2, rs_s2, rw_s2;
    logic                    en_d, rs_d, rw_d;
    logic [PAYLOAD_BITS-1:0] data_d;

    logic             commit, wr_commit, wr_drop;
    logic             is_clear, is_home;
    logic             cell_we;
    logic [4:0]       cell_idx;

    logic [CNT_W-1:0] busy_cnt_q;
    logic [4:0]       clr_idx_q;
    logic [6:0]       ac_q;
    logic             disp_q, cur_q, blink_q, entry_inc_q;
    logic [2:0]       func_q;
    logic             cmd_err_q;
    logic [7:0]       cell_q [32];
    logic [7:0]       rd_char_q;

    // Two-line DDRAM map: line 1 is 0x00-0x27, line 2 is 0x40-0x67
    function automatic logic [6:0] ac_inc(input logic [6:0] ac);
        if (ac == 7'h27)      return 7'h40;
        else if (ac == 7'h67) return 7'h00;
        else                  return ac + 7'd1;
    endfunction

    function automatic logic [6:0] ac_dec(input logic [6:0] ac);
        if (ac == 7'h00)      return 7'h67;
        else if (ac == 7'h40) return 7'h27;
        else                  return ac - 7'd1;
    endfunction

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= {LCD_EN_I, LCD_RS_I, LCD_RW_I, LCD_DATA_I};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign {en_s2, rs_s2, rw_s2} = sync2_q[BUS_W-1 -: 3];
    assign {en_d, rs_d, rw_d}    = sync3_q[BUS_W-1 -: 3];
    assign data_d                = sync3_q[PAYLOAD_BITS-1:0];

    always_comb begin
        commit    = en_d & ~en_s2;
        wr_commit = commit & ~rw_d & (state_q == ST_IDLE);
        wr_drop   = commit & ~rw_d & (state_q != ST_IDLE);
        is_clear  = ~rs_d & (data_d == 8'h01);
        is_home   = ~rs_d & (data_d[7:1] == 7'b0000001);
        // 0x00-0x0F map to cells 0-15, 0x40-0x4F to cells 16-31
        cell_we   = wr_commit & rs_d & ((ac_q[6:4] == 3'b000) | (ac_q[6:4] == 3'b100));
        cell_idx  = {ac_q[6], ac_q[3:0]};
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (wr_commit) state_d = is_clear ? ST_CLEAR : ST_BUSY;
            ST_CLEAR: if (clr_idx_q == 5'd31) state_d = ST_BUSY;
            ST_BUSY:  if (busy_cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The counter runs through CLEAR as well, so the whole busy window of a
    // clear is CLR_CYCLES including the 32 blanking cycles.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            busy_cnt_q <= '0;
            clr_idx_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    clr_idx_q <= '0;
                    if (wr_commit)
                        busy_cnt_q <= (is_clear | is_home) ? CNT_W'(CLR_CYCLES)
                                                           : CNT_W'(CMD_CYCLES);
                end
                ST_CLEAR: begin
                    clr_idx_q  <= clr_idx_q + 5'd1;
                    busy_cnt_q <= busy_cnt_q - CNT_W'(1);
                end
                default: busy_cnt_q <= busy_cnt_q - CNT_W'(1);
            endcase
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ac_q        <= '0;
            disp_q      <= 1'b0;
            cur_q       <= 1'b0;
            blink_q     <= 1'b0;
            entry_inc_q <= 1'b1;
            func_q      <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            cmd_err_q <= wr_drop;
            if (wr_commit) begin
                if (rs_d) begin
                    ac_q <= entry_inc_q ? ac_inc(ac_q) : ac_dec(ac_q);
                end else begin
                    casez (data_d)
                        8'b1???????: ac_q <= data_d[6:0];
                        8'b01??????: ;
                        8'b001?????: func_q <= data_d[4:2];
                        8'b0001????: begin
                            if (!data_d[3])
                                ac_q <= data_d[2] ? ac_inc(ac_q) : ac_dec(ac_q);
                        end
                        8'b00001???: begin
                            disp_q  <= data_d[2];
                            cur_q   <= data_d[1];
                            blink_q <= data_d[0];
                        end
                        8'b000001??: entry_inc_q <= data_d[1];
                        8'b0000001?: ac_q <= '0;
                        8'b00000001: begin
                            ac_q        <= '0;
                            entry_inc_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            for (int i = 0; i < 32; i++) cell_q[i] <= 8'h20;
            rd_char_q <= 8'h20;
        end else begin
            if (state_q == ST_CLEAR)
                cell_q[clr_idx_q] <= 8'h20;
            else if (cell_we)
                cell_q[cell_idx] <= data_d;
            rd_char_q <= cell_q[RD_ADDR_I];
        end
    end

    // Busy-flag read tracks the synced strobe combinationally so the
    // flag can drop while the controller is still holding EN.
    assign BUSY_O        = (state_q != ST_IDLE);
    assign LCD_DATA_OE_O = en_s2 & ~rs_s2 & rw_s2;
    assign LCD_DATA_O    = LCD_DATA_OE_O ? {BUSY_O, ac_q} : '0;
    assign AC_O          = ac_q;
    assign DISP_ON_O     = disp_q;
    assign CUR_ON_O      = cur_q;
    assign BLINK_O       = blink_q;
    assign ENTRY_INC_O   = entry_inc_q;
    assign FUNC_O        = func_q;
    assign CMD_ERR_O     = cmd_err_q;
    assign RD_CHAR_O     = rd_char_q;

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
module tb_lcd_hd44780_rx;

    localparam int C = 60;
    localparam int L = 150;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic [7:0] LCD_DATA_I = 8'h00;
    logic       LCD_RS_I = 1'b0;
    logic       LCD_RW_I = 1'b0;
    logic       LCD_EN_I = 1'b0;
    logic [7:0] LCD_DATA_O;
    logic       LCD_DATA_OE_O;
    logic       BUSY_O;
    logic [6:0] AC_O;
    logic       DISP_ON_O, CUR_ON_O, BLINK_O, ENTRY_INC_O;
    logic [2:0] FUNC_O;
    logic       CMD_ERR_O;
    logic [4:0] RD_ADDR_I = 5'd0;
    logic [7:0] RD_CHAR_O;

    lcd_hd44780_rx #(.PAYLOAD_BITS(8), .CMD_CYCLES(C), .CLR_CYCLES(L)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .LCD_DATA_I(LCD_DATA_I), .LCD_RS_I(LCD_RS_I), .LCD_RW_I(LCD_RW_I), .LCD_EN_I(LCD_EN_I),
        .LCD_DATA_O(LCD_DATA_O), .LCD_DATA_OE_O(LCD_DATA_OE_O),
        .BUSY_O(BUSY_O), .AC_O(AC_O), .DISP_ON_O(DISP_ON_O), .CUR_ON_O(CUR_ON_O),
        .BLINK_O(BLINK_O), .ENTRY_INC_O(ENTRY_INC_O), .FUNC_O(FUNC_O), .CMD_ERR_O(CMD_ERR_O),
        .RD_ADDR_I(RD_ADDR_I), .RD_CHAR_O(RD_CHAR_O)
    );

    always #5 CLK_I = ~CLK_I;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    bit mon_ignore = 1'b0;
    int err_cnt = 0;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         busy;
        logic [6:0] ac;
        logic       e;
        logic [2:0] func;
        logic       disp;
        logic       cur;
        logic       blink;
        int         chk_idx;
        logic [7:0] chk_val;
    } vec_t;

    vec_t vecs[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Busy-window scoreboard: every measured BUSY_O pulse is compared with
    // the length queued when its command was driven.
    initial begin
        int len = 0;
        int e;
        forever begin
            @(negedge CLK_I);
            if (BUSY_O === 1'b1) len++;
            else if (len > 0) begin
                if (!mon_ignore) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL busy_unexpected: got pulse of %0d cycles expected none", len);
                    end else begin
                        e = exp_q.pop_front();
                        check("busy_len", 32'(len), 32'(e));
                    end
                end
                len = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK_I);
            if (CMD_ERR_O === 1'b1) err_cnt++;
        end
    end

    task automatic lcd_write(input logic rs, input logic [7:0] d, input int exp_busy);
        @(posedge CLK_I); #1;
        LCD_RS_I = rs; LCD_RW_I = 1'b0; LCD_DATA_I = d; LCD_EN_I = 1'b1;
        if (exp_busy > 0) exp_q.push_back(exp_busy);
        repeat (4) @(posedge CLK_I); #1;
        LCD_EN_I = 1'b0;
        repeat (4) @(posedge CLK_I); #1;
    endtask

    task automatic bus_read(input logic rs, output logic oe, output logic [7:0] dat);
        @(posedge CLK_I); #1;
        LCD_RS_I = rs; LCD_RW_I = 1'b1; LCD_EN_I = 1'b1;
        repeat (3) @(posedge CLK_I); #1;
        oe = LCD_DATA_OE_O;
        dat = LCD_DATA_O;
        LCD_EN_I = 1'b0;
        repeat (3) @(posedge CLK_I); #1;
        LCD_RW_I = 1'b0;
    endtask

    task automatic wait_ready();
        logic oe;
        logic [7:0] dat;
        int n;
        n = 0;
        dat = 8'h80;
        while (dat[7] && n < 100) begin
            bus_read(1'b0, oe, dat);
            n++;
        end
        if (dat[7]) begin
            checks++;
            errors++;
            $display("FAIL busy_poll_timeout: got busy after %0d polls expected ready", n);
        end
    endtask

    task automatic read_cell(input int idx, output logic [7:0] v);
        @(posedge CLK_I); #1;
        RD_ADDR_I = 5'(idx);
        repeat (2) @(posedge CLK_I); #1;
        v = RD_CHAR_O;
    endtask

    initial begin
        logic [7:0] v;
        logic       oe;
        logic [7:0] dat;
        int         err0;

        //            rs    d      busy ac     e     func    disp  cur   blink chk  val
        vecs[0]  = '{1'b0, 8'h38, C, 7'h00, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, -1, 8'h00};
        vecs[1]  = '{1'b0, 8'h0C, C, 7'h00, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[2]  = '{1'b0, 8'h01, L, 7'h00, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0,  0, 8'h20};
        vecs[3]  = '{1'b0, 8'h06, C, 7'h00, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[4]  = '{1'b0, 8'h80, C, 7'h00, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[5]  = '{1'b1, 8'hE0, C, 7'h01, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0,  0, 8'hE0};
        vecs[6]  = '{1'b1, 8'h41, C, 7'h02, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0,  1, 8'h41};
        vecs[7]  = '{1'b0, 8'h04, C, 7'h02, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[8]  = '{1'b1, 8'h42, C, 7'h01, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0,  2, 8'h42};
        vecs[9]  = '{1'b0, 8'h06, C, 7'h01, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[10] = '{1'b0, 8'hA7, C, 7'h27, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[11] = '{1'b1, 8'h55, C, 7'h40, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 16, 8'h20};
        vecs[12] = '{1'b1, 8'h33, C, 7'h41, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 16, 8'h33};
        vecs[13] = '{1'b0, 8'h10, C, 7'h40, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[14] = '{1'b0, 8'h14, C, 7'h41, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[15] = '{1'b0, 8'h18, C, 7'h41, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[16] = '{1'b0, 8'hE7, C, 7'h67, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[17] = '{1'b1, 8'h77, C, 7'h00, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0,  0, 8'hE0};
        vecs[18] = '{1'b0, 8'h04, C, 7'h00, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[19] = '{1'b0, 8'h10, C, 7'h67, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[20] = '{1'b0, 8'h14, C, 7'h00, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[21] = '{1'b0, 8'h8A, C, 7'h0A, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[22] = '{1'b0, 8'h02, L, 7'h00, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        vecs[23] = '{1'b0, 8'h0F, C, 7'h00, 1'b0, 3'b110, 1'b1, 1'b1, 1'b1, -1, 8'h00};
        vecs[24] = '{1'b0, 8'h40, C, 7'h00, 1'b0, 3'b110, 1'b1, 1'b1, 1'b1, -1, 8'h00};
        vecs[25] = '{1'b0, 8'h07, C, 7'h00, 1'b1, 3'b110, 1'b1, 1'b1, 1'b1, -1, 8'h00};
        vecs[26] = '{1'b0, 8'h24, C, 7'h00, 1'b1, 3'b001, 1'b1, 1'b1, 1'b1, -1, 8'h00};
        vecs[27] = '{1'b0, 8'hC0, C, 7'h40, 1'b1, 3'b001, 1'b1, 1'b1, 1'b1, -1, 8'h00};
        vecs[28] = '{1'b0, 8'h04, C, 7'h40, 1'b0, 3'b001, 1'b1, 1'b1, 1'b1, -1, 8'h00};
        vecs[29] = '{1'b1, 8'h5A, C, 7'h27, 1'b0, 3'b001, 1'b1, 1'b1, 1'b1, 16, 8'h5A};
        vecs[30] = '{1'b0, 8'h01, L, 7'h00, 1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 16, 8'h20};
        vecs[31] = '{1'b1, 8'hAB, C, 7'h01, 1'b1, 3'b001, 1'b1, 1'b1, 1'b1,  0, 8'hAB};

        repeat (3) @(posedge CLK_I); #1;
        RST_I = 1'b0;

        // Reset state
        check("rst_ac", 32'(AC_O), 32'h0);
        check("rst_busy", 32'(BUSY_O), 32'h0);
        check("rst_entry", 32'(ENTRY_INC_O), 32'h1);
        check("rst_oe", 32'(LCD_DATA_OE_O), 32'h0);
        for (int i = 0; i < 32; i++) begin
            read_cell(i, v);
            check($sformatf("rst_cell%0d", i), 32'(v), 32'h20);
        end

        // Command/data table
        for (int i = 0; i < 32; i++) begin
            lcd_write(vecs[i].rs, vecs[i].d, vecs[i].busy);
            wait_ready();
            check($sformatf("vec%0d_state", i),
                  32'({AC_O, ENTRY_INC_O, FUNC_O, DISP_ON_O, CUR_ON_O, BLINK_O}),
                  32'({vecs[i].ac, vecs[i].e, vecs[i].func, vecs[i].disp, vecs[i].cur, vecs[i].blink}));
            if (vecs[i].chk_idx >= 0) begin
                read_cell(vecs[i].chk_idx, v);
                check($sformatf("vec%0d_cell%0d", i, vecs[i].chk_idx), 32'(v), 32'(vecs[i].chk_val));
            end
        end

        // Busy-flag read and write dropped while busy
        lcd_write(1'b0, 8'h8A, C);
        bus_read(1'b0, oe, dat);
        check("busy_read_oe", 32'(oe), 32'h1);
        check("busy_read_data", 32'(dat), 32'h8A);
        err0 = err_cnt;
        lcd_write(1'b0, 8'hC5, 0);
        repeat (2) @(posedge CLK_I); #1;
        check("cmd_err_pulses", 32'(err_cnt - err0), 32'h1);
        wait_ready();
        check("drop_ac", 32'(AC_O), 32'h0A);
        bus_read(1'b1, oe, dat);
        check("rs1_read_oe", 32'(oe), 32'h0);
        bus_read(1'b0, oe, dat);
        check("idle_read_data", 32'({oe, dat}), 32'h10A);

        // Reset in the middle of a clear
        mon_ignore = 1'b1;
        lcd_write(1'b0, 8'h01, 0);
        repeat (10) @(posedge CLK_I); #1;
        check("mid_clear_busy", 32'(BUSY_O), 32'h1);
        RST_I = 1'b1;
        #1;
        check("rst_abort_busy", 32'(BUSY_O), 32'h0);
        repeat (3) @(posedge CLK_I); #1;
        RST_I = 1'b0;
        repeat (2) @(posedge CLK_I); #1;
        mon_ignore = 1'b0;
        check("rst2_ac", 32'(AC_O), 32'h0);
        check("rst2_entry", 32'(ENTRY_INC_O), 32'h1);
        for (int i = 0; i < 32; i++) begin
            read_cell(i, v);
            check($sformatf("rst2_cell%0d", i), 32'(v), 32'h20);
        end

        repeat (4) @(posedge CLK_I); #1;
        check("busy_queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
